// File: rtl/fetch_prefetch_unit.sv
// fetch_prefetch_unit: instruction fetch front end that feeds register_IF_ID.
// Fetches instruction words over a req/ack handshake into a small prefetch
// queue, presents the queue head under Stall, and redirects on JumpEnable.
// Optional build macro FETCH_STATS_EN adds saturating FetchCount/FlushCount.
module fetch_prefetch_unit #(
  parameter int                 DATA_W   = 20,
  parameter int                 ADDR_W   = 20,
  parameter int                 DEPTH    = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              Clock,
  input  logic              Reset,
  output logic              IMemReq,
  output logic [ADDR_W-1:0] IMemAddr,
  input  logic              IMemAck,
  input  logic [DATA_W-1:0] IMemData,
  input  logic              JumpEnable,
  input  logic [ADDR_W-1:0] JumpAddress,
  input  logic              Stall,
  output logic              InstrValid,
  output logic [DATA_W-1:0] Instr,
  output logic [ADDR_W-1:0] InstrPC
`ifdef FETCH_STATS_EN
  ,
  output logic [15:0]       FetchCount,
  output logic [15:0]       FlushCount
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // no request outstanding
    ST_WAIT = 2'd1,  // request outstanding, data will be kept
    ST_DROP = 2'd2   // request outstanding, data will be discarded
  } state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] pc, pc_next;
  logic              req_next;
  logic [ADDR_W-1:0] addr_next;

  logic [ADDR_W-1:0] q_pc   [DEPTH];
  logic [DATA_W-1:0] q_data [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count, count_after;

  logic transfer, push, pop, credit;

  // State register: FSM state, fetch PC and the registered request outputs.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state    <= ST_IDLE;
      pc       <= RESET_PC;
      IMemReq  <= 1'b0;
      IMemAddr <= RESET_PC;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state    <= state_next;
      pc       <= pc_next;
      IMemReq  <= req_next;
      IMemAddr <= addr_next;
    end
  end

  // Next-state logic: issue, complete, discard and redirect fetches.
  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned (no latches).
    state_next = state;
    pc_next    = pc;
    req_next   = IMemReq;
    addr_next  = IMemAddr;
    unique case (state)
      ST_IDLE: begin
        if (JumpEnable) begin
          pc_next = JumpAddress;
        end else if (credit) begin
          req_next   = 1'b1;
          addr_next  = pc;
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (transfer) begin
          if (JumpEnable) begin
            pc_next    = JumpAddress;
            req_next   = 1'b0;
            state_next = ST_IDLE;
          end else begin
            // pc tracks IMemAddr in this state; +1 wraps modulo 2^ADDR_W.
            pc_next = pc + ADDR_W'(1);
            if (credit) begin
              addr_next = pc + ADDR_W'(1);
            end else begin
              req_next   = 1'b0;
              state_next = ST_IDLE;
            end
          end
        end else if (JumpEnable) begin
          // Address must stay put until the memory acks; remember the target.
          pc_next    = JumpAddress;
          state_next = ST_DROP;
        end
      end
      ST_DROP: begin
        if (JumpEnable) pc_next = JumpAddress;
        if (transfer) begin
          req_next   = 1'b0;
          state_next = ST_IDLE;
        end
      end
      default: begin
        req_next   = 1'b0;
        state_next = ST_IDLE;
      end
    endcase
  end

  // Output / control logic: handshake strobes, credit and queue head view.
  always_comb begin
    transfer = IMemReq && IMemAck;
    push     = (state == ST_WAIT) && transfer && !JumpEnable;
    pop      = InstrValid && !Stall && !JumpEnable;

    count_after = count;
    if (push) count_after = count_after + CNT_W'(1);
    if (pop)  count_after = count_after - CNT_W'(1);
    // Any request issued now becomes the single outstanding one after the edge.
    credit = count_after < CNT_W'(DEPTH);

    InstrValid = (count != '0);
    Instr      = InstrValid ? q_data[rd_ptr] : '0;
    InstrPC    = InstrValid ? q_pc[rd_ptr]   : '0;
  end

  // Queue storage write port.
  always_ff @(posedge Clock) begin
    // NOTE: storage is not reset; count alone decides which entries are valid.
    if (push) begin
      q_pc[wr_ptr]   <= IMemAddr;
      q_data[wr_ptr] <= IMemData;
    end
  end

  // Queue pointers and occupancy; a jump flushes everything on the same edge.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (JumpEnable) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_after;
    end
  end

`ifdef FETCH_STATS_EN
  // Saturating statistics: completed transfers (kept or not) and jump cycles.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      FetchCount <= '0;
      FlushCount <= '0;
    end else begin
      if (transfer && (FetchCount != 16'hFFFF))   FetchCount <= FetchCount + 16'd1;
      if (JumpEnable && (FlushCount != 16'hFFFF)) FlushCount <= FlushCount + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed testbench for fetch_prefetch_unit: latency, stall back-pressure,
// redirect during an outstanding fetch, jump with ack and pop, PC wrap and
// asynchronous reset mid-transfer.
module tb_fetch_prefetch_unit;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        IMemReq;
  logic [19:0] IMemAddr;
  logic        IMemAck = 1'b0;
  logic [19:0] IMemData;
  logic        JumpEnable = 1'b0;
  logic [19:0] JumpAddress = '0;
  logic        Stall = 1'b0;
  logic        InstrValid;
  logic [19:0] Instr;
  logic [19:0] InstrPC;
`ifdef FETCH_STATS_EN
  logic [15:0] FetchCount;
  logic [15:0] FlushCount;
`endif

  int n_pass  = 0;
  int n_total = 0;

  fetch_prefetch_unit dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .IMemReq     (IMemReq),
    .IMemAddr    (IMemAddr),
    .IMemAck     (IMemAck),
    .IMemData    (IMemData),
    .JumpEnable  (JumpEnable),
    .JumpAddress (JumpAddress),
    .Stall       (Stall),
    .InstrValid  (InstrValid),
    .Instr       (Instr),
    .InstrPC     (InstrPC)
`ifdef FETCH_STATS_EN
    ,
    .FetchCount  (FetchCount),
    .FlushCount  (FlushCount)
`endif
  );

  always #5 Clock = ~Clock;

  // Instruction memory contents: two fixed words, a simple pattern elsewhere.
  function automatic logic [19:0] mem_word(input logic [19:0] a);
    case (a)
      20'h00000: mem_word = 20'hCF000;
      20'h00001: mem_word = 20'h01F00;
      default:   mem_word = a ^ 20'hA5A5A;
    endcase
  endfunction

  assign IMemData = mem_word(IMemAddr);

  // Advance to the next falling edge: one rising edge has just passed.
  task automatic tick();
    @(negedge Clock);
  endtask

  // Pulse reset, then release it on a falling edge; next rising edge is edge 1.
  task automatic do_reset(input logic ack, input logic stall);
    @(negedge Clock);
    Reset = 1'b0; IMemAck = ack; Stall = stall; JumpEnable = 1'b0; JumpAddress = '0;
    @(negedge Clock);
    Reset = 1'b1;
  endtask

  task automatic test_reset();
    #1 Reset = 1'b0;
    IMemAck = 1'b1;
    #2;
    n_total++; if (IMemReq !== 1'b0) $display("FAIL reset_req: got %0h want 0", IMemReq); else n_pass++;
    n_total++; if (IMemAddr !== 20'h0) $display("FAIL reset_addr: got %0h want 0", IMemAddr); else n_pass++;
    n_total++; if (InstrValid !== 1'b0) $display("FAIL reset_valid: got %0h want 0", InstrValid); else n_pass++;
    n_total++; if (Instr !== 20'h0) $display("FAIL reset_instr: got %0h want 0", Instr); else n_pass++;
    n_total++; if (InstrPC !== 20'h0) $display("FAIL reset_pc: got %0h want 0", InstrPC); else n_pass++;
  endtask

  task automatic test_latency();
    do_reset(1'b1, 1'b0);
    tick();  // edge 1
    n_total++; if (IMemReq !== 1'b1) $display("FAIL lat_req1: got %0h want 1", IMemReq); else n_pass++;
    n_total++; if (IMemAddr !== 20'h0) $display("FAIL lat_addr1: got %0h want 0", IMemAddr); else n_pass++;
    n_total++; if (InstrValid !== 1'b0) $display("FAIL lat_valid1: got %0h want 0", InstrValid); else n_pass++;
    tick();  // edge 2
    n_total++; if (InstrValid !== 1'b1) $display("FAIL lat_valid2: got %0h want 1", InstrValid); else n_pass++;
    n_total++; if (Instr !== 20'hCF000) $display("FAIL lat_instr0: got %0h want cf000", Instr); else n_pass++;
    n_total++; if (InstrPC !== 20'h0) $display("FAIL lat_pc0: got %0h want 0", InstrPC); else n_pass++;
    tick();  // edge 3
    n_total++; if (Instr !== 20'h01F00) $display("FAIL lat_instr1: got %0h want 01f00", Instr); else n_pass++;
    n_total++; if (InstrPC !== 20'h1) $display("FAIL lat_pc1: got %0h want 1", InstrPC); else n_pass++;
    tick();  // edge 4: one instruction per cycle continues
    n_total++; if (InstrPC !== 20'h2) $display("FAIL lat_pc2: got %0h want 2", InstrPC); else n_pass++;
    n_total++; if (Instr !== (20'h2 ^ 20'hA5A5A)) $display("FAIL lat_instr2: got %0h want %0h", Instr, 20'h2 ^ 20'hA5A5A); else n_pass++;
  endtask

  task automatic test_stall();
    int reqs;
    reqs = 0;
    do_reset(1'b1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      tick();
      if (IMemReq) reqs++;
    end
    n_total++; if (reqs !== 4) $display("FAIL stall_transfers: got %0d want 4", reqs); else n_pass++;
    n_total++; if (IMemReq !== 1'b0) $display("FAIL stall_req_off: got %0h want 0", IMemReq); else n_pass++;
    n_total++; if (InstrPC !== 20'h0) $display("FAIL stall_head: got %0h want 0", InstrPC); else n_pass++;
    Stall = 1'b0;
    tick();
    n_total++; if (InstrPC !== 20'h1) $display("FAIL drain_pc1: got %0h want 1", InstrPC); else n_pass++;
    n_total++; if (IMemReq !== 1'b1) $display("FAIL resume_req: got %0h want 1", IMemReq); else n_pass++;
    n_total++; if (IMemAddr !== 20'h4) $display("FAIL resume_addr: got %0h want 4", IMemAddr); else n_pass++;
    tick();
    n_total++; if (InstrPC !== 20'h2) $display("FAIL drain_pc2: got %0h want 2", InstrPC); else n_pass++;
    tick();
    n_total++; if (InstrPC !== 20'h3) $display("FAIL drain_pc3: got %0h want 3", InstrPC); else n_pass++;
    tick();
    n_total++; if (InstrPC !== 20'h4) $display("FAIL drain_pc4: got %0h want 4", InstrPC); else n_pass++;
    n_total++; if (Instr !== (20'h4 ^ 20'hA5A5A)) $display("FAIL drain_instr4: got %0h want %0h", Instr, 20'h4 ^ 20'hA5A5A); else n_pass++;
  endtask

  task automatic test_jump_drop();
    do_reset(1'b0, 1'b0);
    tick();  // edge 1: request for address 0 outstanding
    JumpEnable = 1'b1; JumpAddress = 20'h00100;
    tick();  // edge 2: redirect latched, old request held
    JumpEnable = 1'b0;
    n_total++; if (IMemReq !== 1'b1) $display("FAIL drop_req_held: got %0h want 1", IMemReq); else n_pass++;
    n_total++; if (IMemAddr !== 20'h0) $display("FAIL drop_addr_held: got %0h want 0", IMemAddr); else n_pass++;
    tick();  // edge 3
    n_total++; if (IMemAddr !== 20'h0) $display("FAIL drop_addr_held2: got %0h want 0", IMemAddr); else n_pass++;
    IMemAck = 1'b1;
    tick();  // edge 4: stale data discarded
    n_total++; if (IMemReq !== 1'b0) $display("FAIL drop_req_off: got %0h want 0", IMemReq); else n_pass++;
    n_total++; if (InstrValid !== 1'b0) $display("FAIL drop_discard: got %0h want 0", InstrValid); else n_pass++;
    tick();  // edge 5
    n_total++; if (IMemAddr !== 20'h00100) $display("FAIL drop_new_addr: got %0h want 100", IMemAddr); else n_pass++;
    tick();  // edge 6
    n_total++; if (InstrValid !== 1'b1) $display("FAIL drop_new_valid: got %0h want 1", InstrValid); else n_pass++;
    n_total++; if (InstrPC !== 20'h00100) $display("FAIL drop_new_pc: got %0h want 100", InstrPC); else n_pass++;
  endtask

  task automatic test_jump_ack_pop();
    do_reset(1'b1, 1'b1);
    tick(); tick(); tick();  // edges 1..3: two entries queued, address 2 in flight
    n_total++; if (InstrPC !== 20'h0) $display("FAIL jap_head: got %0h want 0", InstrPC); else n_pass++;
    Stall = 1'b0; JumpEnable = 1'b1; JumpAddress = 20'h02345;
    tick();  // edge 4: jump with ack and pop
    JumpEnable = 1'b0;
    n_total++; if (InstrValid !== 1'b0) $display("FAIL jap_flush: got %0h want 0", InstrValid); else n_pass++;
    n_total++; if (IMemReq !== 1'b0) $display("FAIL jap_req_off: got %0h want 0", IMemReq); else n_pass++;
    tick();  // edge 5
    n_total++; if (IMemAddr !== 20'h02345) $display("FAIL jap_new_addr: got %0h want 2345", IMemAddr); else n_pass++;
    tick();  // edge 6
    n_total++; if (InstrPC !== 20'h02345) $display("FAIL jap_new_pc: got %0h want 2345", InstrPC); else n_pass++;
  endtask

  task automatic test_wrap();
    do_reset(1'b1, 1'b0);
    tick();  // edge 1
    JumpEnable = 1'b1; JumpAddress = 20'hFFFFF;
    tick();  // edge 2: jump with ack
    JumpEnable = 1'b0;
    tick();  // edge 3: request FFFFF
    tick();  // edge 4
    n_total++; if (InstrPC !== 20'hFFFFF) $display("FAIL wrap_pc_top: got %0h want fffff", InstrPC); else n_pass++;
    tick();  // edge 5
    n_total++; if (InstrPC !== 20'h00000) $display("FAIL wrap_pc_zero: got %0h want 0", InstrPC); else n_pass++;
    n_total++; if (Instr !== 20'hCF000) $display("FAIL wrap_instr: got %0h want cf000", Instr); else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset(1'b1, 1'b1);
    tick(); tick(); tick();  // queue holds 2, request outstanding
    #2 Reset = 1'b0;
    #1;
    n_total++; if (IMemReq !== 1'b0) $display("FAIL rmid_req: got %0h want 0", IMemReq); else n_pass++;
    n_total++; if (InstrValid !== 1'b0) $display("FAIL rmid_valid: got %0h want 0", InstrValid); else n_pass++;
    n_total++; if (IMemAddr !== 20'h0) $display("FAIL rmid_addr: got %0h want 0", IMemAddr); else n_pass++;
`ifdef FETCH_STATS_EN
    n_total++; if (FetchCount !== 16'h0) $display("FAIL rmid_fetchcnt: got %0h want 0", FetchCount); else n_pass++;
    n_total++; if (FlushCount !== 16'h0) $display("FAIL rmid_flushcnt: got %0h want 0", FlushCount); else n_pass++;
`endif
    @(negedge Clock);
    Stall = 1'b0;
    Reset = 1'b1;
    tick();  // edge 1
    n_total++; if (IMemAddr !== 20'h0) $display("FAIL rmid_restart_addr: got %0h want 0", IMemAddr); else n_pass++;
    tick();  // edge 2
    n_total++; if (InstrPC !== 20'h0) $display("FAIL rmid_restart_pc: got %0h want 0", InstrPC); else n_pass++;
    n_total++; if (InstrValid !== 1'b1) $display("FAIL rmid_restart_valid: got %0h want 1", InstrValid); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_stall();
    test_jump_drop();
    test_jump_ack_pop();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
